// File: rtl/bip_pkg.sv
// Shared definitions for the BIP run-control sequencer.
// Holds the FSM state encoding, the command/status byte values and the
// result-frame payload layout used by bip_uart_ctrl and bip_frame_mux.
package bip_pkg;

  localparam int unsigned FRAME_LEN   = 7;
  localparam int unsigned IDX_WIDTH   = $clog2(FRAME_LEN);
  localparam int unsigned FIELD_WIDTH = 16;

  localparam logic [7:0] CMD_RUN    = 8'h38;
  localparam logic [7:0] ST_HALT    = 8'h00;
  localparam logic [7:0] ST_TIMEOUT = 8'h01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_LOAD,
    S_WAIT_TX
  } state_t;

  // Latched result fields, each zero-extended to a 16-bit field.
  typedef struct packed {
    logic [7:0]             status;
    logic [FIELD_WIDTH-1:0] acc;
    logic [FIELD_WIDTH-1:0] pc;
    logic [FIELD_WIDTH-1:0] cnt;
  } frame_t;

endpackage

// File: rtl/bip_frame_mux.sv
// Result-frame byte selector.
// Ports:
//   frame - latched status/ACC/PC/count fields
//   idx   - byte index 0..6
//   data  - selected byte: status, ACC hi/lo, PC hi/lo, CNT hi/lo
module bip_frame_mux
  import bip_pkg::*;
(
  input  frame_t                 frame,
  input  logic   [IDX_WIDTH-1:0] idx,
  output logic   [7:0]           data
);

  // MSB-first byte order; out-of-range indices read as zero.
  always_comb begin
    data = '0;
    case (idx)
      3'd0:    data = frame.status;
      3'd1:    data = frame.acc[15:8];
      3'd2:    data = frame.acc[7:0];
      3'd3:    data = frame.pc[15:8];
      3'd4:    data = frame.pc[7:0];
      3'd5:    data = frame.cnt[15:8];
      3'd6:    data = frame.cnt[7:0];
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/bip_uart_ctrl.sv
// Run-control sequencer between the UART and the BIP core.
// Waits for the run command byte, releases the CPU, counts enabled cycles
// until halt or cycle budget, then streams a 7-byte result frame.
// Ports:
//   i_clk, i_rst            - clock, synchronous active-high reset
//   i_rx_data, i_rx_done    - received byte and its one-cycle strobe
//   o_tx_data, o_tx_start   - byte to send and its one-cycle start strobe
//   i_tx_done               - transmitter finished current byte
//   o_cpu_en, o_cpu_rst     - CPU clock enable and synchronous reset
//   i_cpu_halt              - CPU executed HLT (level)
//   i_cpu_acc, i_cpu_pc     - CPU accumulator and program counter
//   o_busy                  - sequencer not idle
module bip_uart_ctrl
  import bip_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH     = 16,
  parameter int unsigned          PC_WIDTH       = 11,
  parameter int unsigned          UART_DATA_SIZE = 8,
  parameter int unsigned          CNT_WIDTH      = 16,
  parameter logic [7:0]           CMD_RUN        = bip_pkg::CMD_RUN,
  parameter logic [CNT_WIDTH-1:0] MAX_CYCLES     = CNT_WIDTH'(16'hFFF0)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [UART_DATA_SIZE-1:0] i_rx_data,
  input  logic                      i_rx_done,
  output logic [UART_DATA_SIZE-1:0] o_tx_data,
  output logic                      o_tx_start,
  input  logic                      i_tx_done,
  output logic                      o_cpu_en,
  output logic                      o_cpu_rst,
  input  logic                      i_cpu_halt,
  input  logic [DATA_WIDTH-1:0]     i_cpu_acc,
  input  logic [PC_WIDTH-1:0]       i_cpu_pc,
  output logic                      o_busy
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = MAX_CYCLES - CNT_WIDTH'(1);
  localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(FRAME_LEN - 1);

  state_t                 state, state_d;
  logic   [CNT_WIDTH-1:0] cnt, cnt_d;
  frame_t                 frame, frame_d;
  logic   [IDX_WIDTH-1:0] idx, idx_d;
  logic   [7:0]           byte_c;

  // Next-state and datapath update.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    frame_d = frame;
    idx_d   = idx;
    unique case (state)
      S_IDLE: begin
        if (i_rx_done && (i_rx_data == UART_DATA_SIZE'(CMD_RUN))) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        // Halt takes priority over timeout when both occur together.
        if (i_cpu_halt || (cnt == CNT_LAST)) begin
          frame_d.status = i_cpu_halt ? ST_HALT : ST_TIMEOUT;
          frame_d.acc    = FIELD_WIDTH'(i_cpu_acc);
          frame_d.pc     = FIELD_WIDTH'(i_cpu_pc);
          frame_d.cnt    = FIELD_WIDTH'(cnt + CNT_WIDTH'(1));
          idx_d          = '0;
          state_d        = S_LOAD;
        end else begin
          cnt_d = cnt + CNT_WIDTH'(1);
        end
      end
      S_LOAD: begin
        state_d = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (i_tx_done) begin
          if (idx == IDX_LAST) begin
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx + IDX_WIDTH'(1);
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Byte for the upcoming LOAD, selected from next-cycle fields.
  bip_frame_mux u_frame_mux (
    .frame (frame_d),
    .idx   (idx_d),
    .data  (byte_c)
  );

  // State, datapath and registered outputs decoded from the next state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      frame      <= '0;
      idx        <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_cpu_en   <= 1'b0;
      o_cpu_rst  <= 1'b1;
      o_busy     <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      frame      <= frame_d;
      idx        <= idx_d;
      o_tx_start <= (state_d == S_LOAD);
      if (state_d == S_LOAD) o_tx_data <= UART_DATA_SIZE'(byte_c);
      o_cpu_en   <= (state_d == S_RUN);
      o_cpu_rst  <= (state_d == S_IDLE) || (state_d == S_CLEAR);
      o_busy     <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_bip_uart_ctrl.sv
// Scoreboard bench for bip_uart_ctrl: expected frame bytes and enabled-cycle
// counts are queued at stimulus time and compared by a negedge monitor.
module tb_bip_uart_ctrl;

  localparam int MAXC = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done;
  logic        cpu_en;
  logic        cpu_rst;
  logic        cpu_halt;
  logic [15:0] cpu_acc;
  logic [10:0] cpu_pc;
  logic        busy;

  always #5 clk = ~clk;

  bip_uart_ctrl #(
    .MAX_CYCLES (16'h0020)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx_data  (rx_data),
    .i_rx_done  (rx_done),
    .o_tx_data  (tx_data),
    .o_tx_start (tx_start),
    .i_tx_done  (tx_done),
    .o_cpu_en   (cpu_en),
    .o_cpu_rst  (cpu_rst),
    .i_cpu_halt (cpu_halt),
    .i_cpu_acc  (cpu_acc),
    .i_cpu_pc   (cpu_pc),
    .o_busy     (busy)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  int         exp_en_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // CPU model: HLT is the instruction executed on enabled cycle number halt_at.
  bit halt_en = 1'b0;
  int halt_at = 0;
  int cpu_cyc = 0;
  always @(posedge clk) begin
    if (cpu_rst) cpu_cyc <= 0;
    else if (cpu_en) cpu_cyc <= cpu_cyc + 1;
  end
  assign cpu_halt = halt_en && (cpu_cyc + 1 >= halt_at);

  // Transmitter model: busy for tx_delay cycles after each start.
  int  tx_delay = 0;
  int  tx_cnt = 0;
  bit  tx_busy = 1'b0;
  initial tx_done = 1'b0;
  always @(posedge clk) begin
    tx_done <= 1'b0;
    if (rst) begin
      tx_busy <= 1'b0;
    end else if (tx_busy) begin
      if (tx_cnt == 0) begin
        tx_done <= 1'b1;
        tx_busy <= 1'b0;
      end else begin
        tx_cnt <= tx_cnt - 1;
      end
    end else if (tx_start) begin
      tx_busy <= 1'b1;
      tx_cnt  <= tx_delay;
    end
  end

  // Monitor: frame bytes, byte hold during waits, enabled-cycle count per run.
  logic [7:0] hold_byte = '0;
  int         en_run = 0;
  bit         prev_en = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      en_run  = 0;
      prev_en = 1'b0;
    end else begin
      if (cpu_en) en_run++;
      if (prev_en && !cpu_en) begin
        if (exp_en_q.size() == 0) check("en_cycles_unexpected", en_run, 0);
        else check("en_cycles", en_run, exp_en_q.pop_front());
        en_run = 0;
      end
      prev_en = cpu_en;
      if (tx_start) begin
        check("tx_start_while_busy", 32'(tx_busy), 0);
        if (exp_q.size() == 0) check("tx_start_unexpected", 1, 0);
        else check("tx_byte", tx_data, exp_q.pop_front());
        hold_byte = tx_data;
      end else if (tx_busy) begin
        check("tx_data_hold", tx_data, hold_byte);
      end
    end
  end

  task automatic send_rx(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  // Queue the reference result for a run, configure the models, issue CMD_RUN.
  // n <= 0 means the CPU never halts.
  task automatic start_frame(input int n, input logic [15:0] acc, input logic [10:0] pc,
                             input int dly);
    logic [7:0]  st;
    int          c;
    logic [15:0] c16;
    if (n <= 0 || n > MAXC) begin
      st = 8'h01;
      c  = MAXC;
    end else begin
      st = 8'h00;
      c  = n;
    end
    c16 = 16'(c);
    exp_q.push_back(st);
    exp_q.push_back(acc[15:8]);
    exp_q.push_back(acc[7:0]);
    exp_q.push_back({5'b0, pc[10:8]});
    exp_q.push_back(pc[7:0]);
    exp_q.push_back(c16[15:8]);
    exp_q.push_back(c16[7:0]);
    exp_en_q.push_back(c);
    halt_en  = (n > 0);
    halt_at  = n;
    cpu_acc  = acc;
    cpu_pc   = pc;
    tx_delay = dly;
    send_rx(8'h38);
  endtask

  // Wait for the frame to finish; optionally inject CMD_RUN mid-send.
  task automatic wait_idle(input bit inject);
    bit done = 1'b0;
    for (int k = 0; k < 8000; k++) begin
      @(posedge clk); #1;
      rx_done = 1'b0;
      if (!busy) begin
        done = 1'b1;
        break;
      end
      if (inject && k == 50) begin
        rx_data = 8'h38;
        rx_done = 1'b1;
      end
    end
    rx_done = 1'b0;
    check("idle_reached", 32'(done), 1);
    check("frame_drained", exp_q.size(), 0);
    check("idle_cpu_rst", 32'(cpu_rst), 1);
    check("idle_cpu_en", 32'(cpu_en), 0);
    repeat (4) @(posedge clk);
    #1;
    check("stay_idle", 32'(busy), 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] junk;
    bit         reached;
    rst     = 1'b1;
    rx_data = '0;
    rx_done = 1'b0;
    cpu_acc = '0;
    cpu_pc  = '0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_cpu_en", 32'(cpu_en), 0);
    check("rst_cpu_rst", 32'(cpu_rst), 1);
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_tx_data", tx_data, 0);
    rst = 1'b0;

    // Run to halt after 10 enabled cycles.
    start_frame(10, 16'h1234, 11'h005, 3);
    wait_idle(1'b0);

    // Wrong command byte is ignored.
    send_rx(8'h41);
    for (int i = 0; i < 3; i++) begin
      check("wrong_cmd_busy", 32'(busy), 0);
      check("wrong_cmd_cpu_en", 32'(cpu_en), 0);
      check("wrong_cmd_cpu_rst", 32'(cpu_rst), 1);
      @(posedge clk); #1;
    end

    // Timeout, then halt coinciding with the last budget cycle.
    start_frame(0, 16'hBEEF, 11'h7FF, 2);
    wait_idle(1'b0);
    start_frame(MAXC, 16'h0F0F, 11'h123, 1);
    wait_idle(1'b0);

    // Back-pressure with a run command arriving mid-send.
    start_frame(7, 16'hA55A, 11'h3C3, 400);
    wait_idle(1'b1);

    // Reset while byte 3 is in flight, then a fresh frame.
    start_frame(12, 16'hCAFE, 11'h456, 30);
    reached = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      if (exp_q.size() <= 3) begin
        reached = 1'b1;
        break;
      end
    end
    check("byte3_started", 32'(reached), 1);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    exp_en_q.delete();
    @(posedge clk); #1;
    check("midsend_rst_busy", 32'(busy), 0);
    check("midsend_rst_cpu_rst", 32'(cpu_rst), 1);
    check("midsend_rst_tx_start", 32'(tx_start), 0);
    rst = 1'b0;
    repeat (600) @(posedge clk);
    #1;
    check("post_rst_idle", 32'(busy), 0);
    start_frame(9, 16'h7E81, 11'h600, 4);
    wait_idle(1'b0);

    // Randomized runs with stray non-command bytes.
    for (int r = 0; r < 8; r++) begin
      junk = 8'($urandom_range(0, 255));
      if (junk == 8'h38) junk = 8'h39;
      send_rx(junk);
      check("junk_ignored", 32'(busy), 0);
      start_frame($urandom_range(2, 40), 16'($urandom), 11'($urandom_range(0, 2047)),
                  $urandom_range(0, 20));
      wait_idle(1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
